// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 keypad encoder.
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Indexed as KEY_MAP[row][col]; row 3 is "* 0 # D" with * = E and # = F.
  localparam logic [0:ROWS-1][0:COLS-1][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic one_low(input logic [COLS-1:0] col);
    return ($countones(~col) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [COLS-1:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = 0; c < COLS; c++) begin
      if (!col[c]) idx = 2'(c);
    end
    return idx;
  endfunction

  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up column inputs.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [COLS-1:0] i_col,
  output logic [COLS-1:0] o_col
);
  logic [COLS-1:0] meta_q;
  logic [COLS-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= i_col;
      sync_q <= meta_q;
    end
  end

  assign o_col = sync_q;
endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/debouncer with a valid/ready hex-code output.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 400
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  output logic [ROWS-1:0] o_row,
  input  logic [COLS-1:0] i_col,
  output logic [3:0]      o_key,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_overflow
);
  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

  logic [COLS-1:0]   col_s;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;
  state_t            state_q;
  logic [1:0]        row_q;
  logic [1:0]        col_q;
  logic [CNT_W-1:0]  deb_cnt_q;
  logic [CNT_W-1:0]  rel_cnt_q;
  logic [ROWS-1:0]   row_o_q;
  logic [3:0]        key_q;
  logic              valid_q;
  logic              ovf_q;

  logic              single_low;
  logic [1:0]        col_idx;
  logic              all_high;
  logic              same_low;
  logic              deb_done;
  logic              rel_done;
  logic              emit_d;
  logic [3:0]        code_d;

  keypad_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_col   (i_col),
    .o_col   (col_s)
  );

  assign tick       = i_en && (tick_cnt_q == TICK_W'(SCAN_DIV - 1));
  assign single_low = one_low(col_s);
  assign col_idx    = low_index(col_s);
  assign all_high   = &col_s;
  assign same_low   = single_low && (col_idx == col_q);
  assign deb_done   = (deb_cnt_q == CNT_W'(DEBOUNCE_CNT - 1));
  assign rel_done   = (rel_cnt_q == CNT_W'(DEBOUNCE_CNT - 1));

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  logic [REP_W-1:0] rep_cnt_q;
  logic             key_low;
  logic             rep_done;
  assign key_low  = !col_s[col_q];
  assign rep_done = (rep_cnt_q == REP_W'(REPEAT_TICKS - 1));
`endif

  always_comb begin
    emit_d = 1'b0;
    code_d = KEY_MAP[row_q][col_q];
    if (tick) begin
      case (state_q)
        SCAN: begin
          // A one-sample debounce needs no DEBOUNCE stay: emit on detection.
          if (single_low && (DEBOUNCE_CNT == 1)) begin
            emit_d = 1'b1;
            code_d = KEY_MAP[row_q][col_idx];
          end
        end
        DEBOUNCE: begin
          if (same_low && deb_done) emit_d = 1'b1;
        end
`ifdef KEYPAD_REPEAT_EN
        HELD: begin
          if (key_low && rep_done) emit_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_q <= '0;
      state_q    <= SCAN;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      row_o_q    <= 4'hF;
      key_q      <= 4'h0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      ovf_q <= 1'b0;
      if (emit_d) begin
        if (!valid_q || i_ready) begin
          key_q   <= code_d;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end

      if (!i_en) begin
        tick_cnt_q <= '0;
        state_q    <= SCAN;
        row_q      <= 2'd0;
        deb_cnt_q  <= '0;
        rel_cnt_q  <= '0;
        row_o_q    <= 4'hF;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_q  <= '0;
`endif
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
        row_o_q    <= row_drive(row_q);
        if (tick) begin
          case (state_q)
            SCAN: begin
              if (single_low) begin
                col_q <= col_idx;
                if (DEBOUNCE_CNT == 1) begin
                  state_q   <= HELD;
                  rel_cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_q <= '0;
`endif
                end else begin
                  state_q   <= DEBOUNCE;
                  deb_cnt_q <= CNT_W'(1);
                end
              end else begin
                row_q   <= row_q + 2'd1;
                row_o_q <= row_drive(row_q + 2'd1);
              end
            end
            DEBOUNCE: begin
              if (same_low) begin
                if (deb_done) begin
                  state_q   <= HELD;
                  deb_cnt_q <= '0;
                  rel_cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_q <= '0;
`endif
                end else begin
                  deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                end
              end else begin
                state_q   <= SCAN;
                deb_cnt_q <= '0;
                row_q     <= row_q + 2'd1;
                row_o_q   <= row_drive(row_q + 2'd1);
              end
            end
            HELD: begin
              if (all_high) begin
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_q <= '0;
`endif
                if (rel_done) begin
                  state_q   <= SCAN;
                  rel_cnt_q <= '0;
                  row_q     <= row_q + 2'd1;
                  row_o_q   <= row_drive(row_q + 2'd1);
                end else begin
                  rel_cnt_q <= rel_cnt_q + CNT_W'(1);
                end
              end else begin
                rel_cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                if (key_low) rep_cnt_q <= rep_done ? '0 : rep_cnt_q + REP_W'(1);
`endif
              end
            end
            default: begin
              state_q <= SCAN;
            end
          endcase
        end
      end
    end
  end

  assign o_row      = row_o_q;
  assign o_key      = key_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder with a behavioural keypad and emit scoreboard.
module tb_keypad_encoder;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        valid;
  logic        ovf;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [3:0] got_key[$];
  int         got_t[$];

  keypad_encoder #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .o_row      (row),
    .i_col      (col),
    .o_key      (key),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && valid && ready) begin
      got_key.push_back(key);
      got_t.push_back(cyc);
      $display("txn: cycle=%0d key=%h", cyc, key);
    end
    if (ovf) ovf_cnt <= ovf_cnt + 1;
  end

  function automatic logic [3:0] ref_code(input int r, input int c);
    logic [3:0] tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    return tbl[r*4+c];
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] cur);
    case (cur)
      4'hE: return 4'hD;
      4'hD: return 4'hB;
      4'hB: return 4'h7;
      4'h7: return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    wait_cycles(n * SCAN_DIV);
  endtask

  task automatic wait_row(input logic [3:0] want);
    int k;
    k = 0;
    while (row !== want && k < 100) begin
      wait_cycles(1);
      k++;
    end
    total++;
    if (row !== want) begin
      bad++;
      $display("FAIL wait_row got=%h want=%h", row, want);
    end
  endtask

  task automatic count_after(input int t0, output int n);
    n = 0;
    foreach (got_t[i]) if (got_t[i] > t0) n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; ready = 1'b1; pressed = '0;
    wait_cycles(3);
    total += 4;
    if (row !== 4'hF)  begin bad++; $display("FAIL reset_row got=%h want=F", row); end
    if (key !== 4'h0)  begin bad++; $display("FAIL reset_key got=%h want=0", key); end
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (row !== 4'hE) begin bad++; $display("FAIL first_row got=%h want=E", row); end
  endtask

  task automatic test_press(input int r, input int c, input int hold, input string name);
    int rel_t, n;
    got_key.delete(); got_t.delete();
    ready = 1'b1;
    pressed[r*4+c] = 1'b1;
    wait_ticks(hold);
    pressed = '0;
    rel_t = cyc;
    wait_ticks(12);
    count_after(rel_t + 3, n);
    total++;
    if (n != 0) begin bad++; $display("FAIL %s_after_release got=%0d want=0", name, n); end
`ifndef KEYPAD_REPEAT_EN
    total++;
    if (got_key.size() != 1) begin
      bad++; $display("FAIL %s_count got=%0d want=1", name, got_key.size());
    end
`endif
    total++;
    if (got_key.size() == 0) begin
      bad++; $display("FAIL %s_code got=none want=%h", name, ref_code(r, c));
    end else begin
      foreach (got_key[i]) if (got_key[i] !== ref_code(r, c)) begin
        bad++; $display("FAIL %s_code got=%h want=%h", name, got_key[i], ref_code(r, c));
        break;
      end
    end
  endtask

  task automatic test_bounce();
    got_key.delete(); got_t.delete();
    ready = 1'b1;
    pressed[0] = 1'b1;
    wait_ticks(2);
    pressed = '0;
    wait_ticks(6);
    total++;
    if (got_key.size() != 0) begin
      bad++; $display("FAIL bounce_emit got=%0d want=0", got_key.size());
    end
    test_press(0, 0, 10, "bounce_hold");
  endtask

  task automatic test_overflow();
    int ovf0;
    got_key.delete(); got_t.delete();
    ready = 1'b0;
    ovf0 = ovf_cnt;
    pressed[13] = 1'b1; wait_ticks(12); pressed = '0; wait_ticks(8);
    pressed[11] = 1'b1; wait_ticks(12); pressed = '0; wait_ticks(8);
    total += 3;
    if (valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", valid); end
    if (key !== 4'h0)   begin bad++; $display("FAIL ovf_key got=%h want=0", key); end
`ifndef KEYPAD_REPEAT_EN
    if (ovf_cnt - ovf0 != 1) begin
      bad++; $display("FAIL ovf_pulses got=%0d want=1", ovf_cnt - ovf0);
    end
`else
    if (ovf_cnt - ovf0 < 1) begin
      bad++; $display("FAIL ovf_pulses got=%0d want>=1", ovf_cnt - ovf0);
    end
`endif
    en = 1'b0;
    wait_cycles(3);
    total += 3;
    if (row !== 4'hF)   begin bad++; $display("FAIL dis_row got=%h want=F", row); end
    if (valid !== 1'b1) begin bad++; $display("FAIL dis_valid got=%b want=1", valid); end
    if (key !== 4'h0)   begin bad++; $display("FAIL dis_key got=%h want=0", key); end
    ready = 1'b1;
    wait_cycles(1);
    ready = 1'b0;
    total += 2;
    if (valid !== 1'b0) begin bad++; $display("FAIL accept_valid got=%b want=0", valid); end
    if (got_key.size() != 1 || got_key[0] !== 4'h0) begin
      bad++; $display("FAIL accept_txn got=%0d want=1", got_key.size());
    end
    en = 1'b1;
    ready = 1'b1;
    wait_ticks(2);
  endtask

  task automatic test_ghost();
    logic [3:0] prev, want;
    int changes;
    got_key.delete(); got_t.delete();
    ready = 1'b1;
    pressed[1] = 1'b1; pressed[2] = 1'b1;
    wait_cycles(2);
    prev = row;
    changes = 0;
    for (int k = 0; k < 24 * SCAN_DIV; k++) begin
      wait_cycles(1);
      if (row !== prev) begin
        want = next_row(prev);
        total++;
        if (row !== want) begin
          bad++; $display("FAIL ghost_row got=%h want=%h", row, want);
        end
        changes++;
        prev = row;
      end
    end
    pressed = '0;
    total += 2;
    if (changes < 20) begin bad++; $display("FAIL ghost_steps got=%0d want>=20", changes); end
    if (got_key.size() != 0) begin
      bad++; $display("FAIL ghost_emit got=%0d want=0", got_key.size());
    end
  endtask

  task automatic test_reset_mid();
    got_key.delete(); got_t.delete();
    ready = 1'b1;
    pressed = '0;
    wait_row(4'hE);
    pressed[15] = 1'b1;
    wait_row(4'h7);
    wait_cycles(6);
    total++;
    if (got_key.size() != 0) begin
      bad++; $display("FAIL mid_pre_emit got=%0d want=0", got_key.size());
    end
    #2 rst_n = 1'b0;
    #1;
    total += 2;
    if (row !== 4'hF)   begin bad++; $display("FAIL mid_rst_row got=%h want=F", row); end
    if (valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", valid); end
    pressed = '0;
    wait_cycles(2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (row !== 4'hE) begin bad++; $display("FAIL mid_resume_row got=%h want=E", row); end
    wait_ticks(10);
    total++;
    if (got_key.size() != 0) begin
      bad++; $display("FAIL mid_post_emit got=%0d want=0", got_key.size());
    end
  endtask

  task automatic test_random();
    int r, c, h;
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      h = int'($urandom_range(10, 16));
      test_press(r, c, h, "random");
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int rel_t, n;
    got_key.delete(); got_t.delete();
    ready = 1'b1;
    pressed[12] = 1'b1;
    wait_ticks(20);
    pressed = '0;
    rel_t = cyc;
    wait_ticks(10);
    count_after(rel_t + 3, n);
    total += 2;
    if (n != 0) begin bad++; $display("FAIL rep_after_release got=%0d want=0", n); end
    if (got_key.size() < 3) begin
      bad++; $display("FAIL rep_count got=%0d want>=3", got_key.size());
    end
    foreach (got_key[i]) begin
      total++;
      if (got_key[i] !== 4'hE) begin
        bad++; $display("FAIL rep_code got=%h want=E", got_key[i]);
      end
      if (i > 0) begin
        total++;
        if (got_t[i] - got_t[i-1] != REPEAT_TICKS * SCAN_DIV) begin
          bad++; $display("FAIL rep_spacing got=%0d want=%0d",
                          got_t[i] - got_t[i-1], REPEAT_TICKS * SCAN_DIV);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press(1, 2, 40, "single");
    test_bounce();
    test_overflow();
    test_ghost();
    wait_ticks(8);
    test_reset_mid();
    test_random();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
